// File: rtl/mdom_wvb_hdr_builder.sv
// Waveform-buffer header builder: tracks each triggered waveform as it is written,
// splits long waveforms into MAX_SEG_LEN segments and writes one 104-bit bundle per segment.
module mdom_wvb_hdr_builder #(
    parameter int MAX_SEG_LEN = 256,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [48:0]       ltc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              trig_start,
    input  logic              trig_stop,
    input  logic [1:0]        trig_src,
    input  logic              cnst_run,
    input  logic [4:0]        pre_conf,
    input  logic              sync_rdy,
    input  logic [18:0]       bsum,
    input  logic [2:0]        bsum_len_sel,
    input  logic              bsum_valid,
    input  logic              local_coinc,
    input  logic              hdr_full,
    output logic [103:0]      hdr_data,
    output logic              hdr_wr_en,
    output logic              hdr_drop,
    output logic              hdr_overflow,
    output logic              active
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    typedef struct packed {
        logic              continued_wfm;
        logic              partial_wfm;
        logic              local_coinc;
        logic              bsum_valid;
        logic [2:0]        bsum_len_sel;
        logic [18:0]       bsum;
        logic              sync_rdy;
        logic [4:0]        pre_conf;
        logic              cnst_run;
        logic [1:0]        trig_src;
        logic [ADDR_W-1:0] stop_addr;
        logic [ADDR_W-1:0] start_addr;
        logic [48:0]       evt_ltc;
    } hdr_t;

    localparam logic [9:0]        SEG_LAST = 10'(MAX_SEG_LEN);
    localparam logic [9:0]        CNT_ONE  = 10'd1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [48:0]       LTC_STEP = 49'(MAX_SEG_LEN);

    state_e       state_q, state_d;
    hdr_t         seg_q, seg_d;          // open segment; local_coinc holds the running OR
    logic [9:0]   seg_cnt_q, seg_cnt_d;
    logic [103:0] hdr_data_q, hdr_data_d;
    logic         hdr_wr_en_q, hdr_wr_en_d;
    logic         hdr_drop_q, hdr_drop_d;
    logic         hdr_overflow_q, hdr_overflow_d;

    hdr_t         bundle;
    logic         emit;
    logic         lc_acc;
    logic [9:0]   seg_cnt_inc;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        seg_d          = seg_q;
        seg_cnt_d      = seg_cnt_q;
        hdr_data_d     = hdr_data_q;
        hdr_wr_en_d    = 1'b0;
        hdr_drop_d     = 1'b0;
        hdr_overflow_d = hdr_overflow_q;
        bundle         = seg_q;
        emit           = 1'b0;
        lc_acc         = seg_q.local_coinc | local_coinc;
        seg_cnt_inc    = seg_cnt_q + CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (trig_start) begin
                    seg_d.evt_ltc       = ltc;
                    seg_d.start_addr    = wr_addr;
                    seg_d.stop_addr     = wr_addr;
                    seg_d.trig_src      = trig_src;
                    seg_d.cnst_run      = cnst_run;
                    seg_d.pre_conf      = pre_conf;
                    seg_d.sync_rdy      = sync_rdy;
                    seg_d.bsum          = bsum;
                    seg_d.bsum_len_sel  = bsum_len_sel;
                    seg_d.bsum_valid    = bsum_valid;
                    seg_d.local_coinc   = local_coinc;
                    seg_d.partial_wfm   = 1'b0;
                    seg_d.continued_wfm = 1'b0;
                    if (trig_stop) begin
                        bundle    = seg_d;
                        emit      = 1'b1;
                        seg_cnt_d = '0;
                    end else begin
                        seg_cnt_d = CNT_ONE;
                        state_d   = ACTIVE;
                    end
                end
            end

            ACTIVE: begin
                bundle.stop_addr   = wr_addr;
                bundle.local_coinc = lc_acc;
                bundle.partial_wfm = 1'b0;
                if (trig_stop) begin
                    emit      = 1'b1;
                    seg_cnt_d = '0;
                    state_d   = IDLE;
                end else if (seg_cnt_inc == SEG_LAST) begin
                    // Split: the next segment begins with the sample written next cycle.
                    bundle.partial_wfm  = 1'b1;
                    emit                = 1'b1;
                    seg_d.start_addr    = wr_addr + ADDR_ONE;
                    seg_d.evt_ltc       = seg_q.evt_ltc + LTC_STEP;
                    seg_d.continued_wfm = 1'b1;
                    seg_d.local_coinc   = 1'b0;
                    seg_cnt_d           = '0;
                end else begin
                    seg_d.local_coinc = lc_acc;
                    seg_cnt_d         = seg_cnt_inc;
                end
            end

            default: state_d = IDLE;
        endcase

        if (emit) begin
            if (hdr_full) begin
                hdr_drop_d     = 1'b1;
                hdr_overflow_d = 1'b1;
            end else begin
                hdr_wr_en_d = 1'b1;
                hdr_data_d  = bundle;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            seg_q          <= '0;
            seg_cnt_q      <= '0;
            hdr_data_q     <= '0;
            hdr_wr_en_q    <= 1'b0;
            hdr_drop_q     <= 1'b0;
            hdr_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seg_q          <= seg_d;
            seg_cnt_q      <= seg_cnt_d;
            hdr_data_q     <= hdr_data_d;
            hdr_wr_en_q    <= hdr_wr_en_d;
            hdr_drop_q     <= hdr_drop_d;
            hdr_overflow_q <= hdr_overflow_d;
        end
    end

    assign hdr_data     = hdr_data_q;
    assign hdr_wr_en    = hdr_wr_en_q;
    assign hdr_drop     = hdr_drop_q;
    assign hdr_overflow = hdr_overflow_q;
    assign active       = (state_q == ACTIVE);

endmodule

// File: tb/tb_mdom_wvb_hdr_builder.sv
// Scoreboard bench for mdom_wvb_hdr_builder: directed waveforms push expected headers,
// a negedge monitor pops and compares every write/drop the DUT presents.
module tb_mdom_wvb_hdr_builder;

    logic         clk = 1'b0;
    logic         rst;
    logic [48:0]  ltc;
    logic [9:0]   wr_addr;
    logic         trig_start;
    logic         trig_stop;
    logic [1:0]   trig_src;
    logic         cnst_run;
    logic [4:0]   pre_conf;
    logic         sync_rdy;
    logic [18:0]  bsum;
    logic [2:0]   bsum_len_sel;
    logic         bsum_valid;
    logic         local_coinc;
    logic         hdr_full;
    logic [103:0] hdr_data;
    logic         hdr_wr_en;
    logic         hdr_drop;
    logic         hdr_overflow;
    logic         active;

    always #5 clk = ~clk;

    mdom_wvb_hdr_builder #(.MAX_SEG_LEN(256), .ADDR_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .ltc          (ltc),
        .wr_addr      (wr_addr),
        .trig_start   (trig_start),
        .trig_stop    (trig_stop),
        .trig_src     (trig_src),
        .cnst_run     (cnst_run),
        .pre_conf     (pre_conf),
        .sync_rdy     (sync_rdy),
        .bsum         (bsum),
        .bsum_len_sel (bsum_len_sel),
        .bsum_valid   (bsum_valid),
        .local_coinc  (local_coinc),
        .hdr_full     (hdr_full),
        .hdr_data     (hdr_data),
        .hdr_wr_en    (hdr_wr_en),
        .hdr_drop     (hdr_drop),
        .hdr_overflow (hdr_overflow),
        .active       (active)
    );

    typedef struct {
        int unsigned  cyc;
        bit           drop;
        logic [103:0] data;
    } exp_t;

    exp_t         sb[$];
    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [103:0] last_written = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [103:0] mk_hdr(
        input logic [48:0] t, input logic [9:0] sa, input logic [9:0] sp,
        input logic [1:0] src, input logic cr, input logic [4:0] pc, input logic sr,
        input logic [18:0] bs, input logic [2:0] bl, input logic bv,
        input logic lc, input logic pw, input logic cw);
        logic [103:0] h;
        h          = '0;
        h[48:0]    = t;
        h[58:49]   = sa;
        h[68:59]   = sp;
        h[70:69]   = src;
        h[71]      = cr;
        h[76:72]   = pc;
        h[77]      = sr;
        h[96:78]   = bs;
        h[99:97]   = bl;
        h[100]     = bv;
        h[101]     = lc;
        h[102]     = pw;
        h[103]     = cw;
        return h;
    endfunction

    task automatic push(input int unsigned at, input bit drop, input logic [103:0] d);
        exp_t e;
        e.cyc  = at;
        e.drop = drop;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_side(input logic [1:0] src, input logic cr, input logic [4:0] pc,
                            input logic sr, input logic [18:0] bs, input logic [2:0] bl,
                            input logic bv);
        trig_src     = src;
        cnst_run     = cr;
        pre_conf     = pc;
        sync_rdy     = sr;
        bsum         = bs;
        bsum_len_sel = bl;
        bsum_valid   = bv;
    endtask

    // Drives n samples from address a0; side fields are scrambled after the start sample.
    task automatic run_wfm(input int a0, input logic [48:0] t0, input int n,
                           input int lc_at, input int junk_start_at, input bit full_last);
        for (int k = 0; k < n; k++) begin
            wr_addr     = 10'((a0 + k) % 1024);
            ltc         = t0 + 49'(k);
            trig_start  = (k == 0) || (k == junk_start_at);
            trig_stop   = (k == n - 1);
            local_coinc = (k == lc_at);
            hdr_full    = full_last && (k == n - 1);
            if (k == 1) set_side(~trig_src, ~cnst_run, ~pre_conf, ~sync_rdy, ~bsum, ~bsum_len_sel, ~bsum_valid);
            step();
        end
        trig_start  = 1'b0;
        trig_stop   = 1'b0;
        local_coinc = 1'b0;
        hdr_full    = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (hdr_wr_en === 1'b1 || hdr_drop === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_emit", 104'({hdr_wr_en, hdr_drop}), 104'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("emit_kind", 104'({hdr_wr_en, hdr_drop}), e.drop ? 104'(2'b01) : 104'(2'b10));
                    check("emit_cycle", 104'(cyc), 104'(e.cyc));
                    if (!e.drop) begin
                        check("hdr_data", hdr_data, e.data);
                        last_written = e.data;
                    end else begin
                        check("hdr_data_hold", hdr_data, last_written);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        ltc         = '0;
        wr_addr     = '0;
        trig_start  = 1'b0;
        trig_stop   = 1'b0;
        local_coinc = 1'b0;
        hdr_full    = 1'b0;
        set_side(2'd0, 1'b0, 5'd0, 1'b0, 19'd0, 3'd0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("reset_hdr_data", hdr_data, 104'(0));
        check("reset_wr_en", 104'(hdr_wr_en), 104'(0));
        check("reset_drop", 104'(hdr_drop), 104'(0));
        check("reset_overflow", 104'(hdr_overflow), 104'(0));
        check("reset_active", 104'(active), 104'(0));
        rst = 1'b0;
        step();

        // Basic 20-sample waveform 100..119.
        set_side(2'd2, 1'b1, 5'h0A, 1'b1, 19'h12345, 3'd3, 1'b1);
        push(cyc + 20, 1'b0, mk_hdr(49'h1000, 10'd100, 10'd119, 2'd2, 1'b1, 5'h0A, 1'b1,
                                    19'h12345, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        run_wfm(100, 49'h1000, 20, -1, -1, 1'b0);
        @(negedge clk);
        check("active_after_stop", 104'(active), 104'(0));

        // 600 samples split into 256/256/88; coincidence only in the middle segment,
        // and a stray trig_start mid-waveform must be ignored.
        set_side(2'd1, 1'b0, 5'h03, 1'b0, 19'h7FFFF, 3'd5, 1'b0);
        push(cyc + 256, 1'b0, mk_hdr(49'd0, 10'd0, 10'd255, 2'd1, 1'b0, 5'h03, 1'b0,
                                     19'h7FFFF, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0));
        push(cyc + 512, 1'b0, mk_hdr(49'd256, 10'd256, 10'd511, 2'd1, 1'b0, 5'h03, 1'b0,
                                     19'h7FFFF, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1));
        push(cyc + 600, 1'b0, mk_hdr(49'd512, 10'd512, 10'd599, 2'd1, 1'b0, 5'h03, 1'b0,
                                     19'h7FFFF, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1));
        run_wfm(0, 49'd0, 600, 300, 100, 1'b0);

        // One-sample waveform at the top address.
        set_side(2'd3, 1'b1, 5'h1F, 1'b1, 19'h00000, 3'd0, 1'b1);
        push(cyc + 1, 1'b0, mk_hdr(49'h1_2345_6789, 10'd1023, 10'd1023, 2'd3, 1'b1, 5'h1F, 1'b1,
                                   19'h00000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        run_wfm(1023, 49'h1_2345_6789, 1, 0, -1, 1'b0);
        @(negedge clk);
        check("active_one_sample", 104'(active), 104'(0));

        // Back-to-back: wraps 1023->0, 40 samples from 1000 end at 15.
        set_side(2'd0, 1'b0, 5'h11, 1'b0, 19'h00ABC, 3'd7, 1'b0);
        push(cyc + 40, 1'b0, mk_hdr(49'h2000, 10'd1000, 10'd15, 2'd0, 1'b0, 5'h11, 1'b0,
                                    19'h00ABC, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        run_wfm(1000, 49'h2000, 40, -1, -1, 1'b0);

        // FIFO full at emit: drop pulse, sticky overflow, data held.
        set_side(2'd1, 1'b1, 5'h05, 1'b0, 19'h11111, 3'd2, 1'b1);
        push(cyc + 5, 1'b1, '0);
        run_wfm(200, 49'h2800, 5, -1, -1, 1'b1);
        @(negedge clk);
        check("overflow_set", 104'(hdr_overflow), 104'(1));

        set_side(2'd1, 1'b1, 5'h00, 1'b1, 19'h40000, 3'd1, 1'b1);
        push(cyc + 3, 1'b0, mk_hdr(49'h3000, 10'd300, 10'd302, 2'd1, 1'b1, 5'h00, 1'b1,
                                   19'h40000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        run_wfm(300, 49'h3000, 3, -1, -1, 1'b0);
        @(negedge clk);
        check("overflow_sticky", 104'(hdr_overflow), 104'(1));

        // Reset mid-segment aborts without a header.
        wr_addr = 10'd500;
        trig_start = 1'b1;
        step();
        trig_start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            wr_addr = 10'(500 + k);
            step();
        end
        @(negedge clk);
        check("active_mid_segment", 104'(active), 104'(1));
        rst = 1'b1;
        wr_addr = 10'd510;
        step();
        @(negedge clk);
        check("active_after_rst", 104'(active), 104'(0));
        check("overflow_after_rst", 104'(hdr_overflow), 104'(0));
        check("wr_en_after_rst", 104'(hdr_wr_en), 104'(0));
        rst = 1'b0;
        step();

        // Normal operation resumes after the abort.
        set_side(2'd2, 1'b0, 5'h0C, 1'b1, 19'h0F0F0, 3'd4, 1'b0);
        push(cyc + 4, 1'b0, mk_hdr(49'h4000, 10'd600, 10'd603, 2'd2, 1'b0, 5'h0C, 1'b1,
                                   19'h0F0F0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        run_wfm(600, 49'h4000, 4, -1, -1, 1'b0);

        repeat (5) step();
        @(negedge clk);
        check("scoreboard_empty", 104'(sb.size()), 104'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
